// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM encoding, loss counter
// width and the qualification/hold counter width helper.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  localparam int LOSS_COUNT_W = 8;

  // Wide enough to reach the larger terminal count; never narrower than 1 bit
  // so STABLE_CYCLES = HOLD_CYCLES = 1 still yields a legal vector.
  function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
    int max_cycles;
    max_cycles = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with asynchronous active-high reset.
// Usable for any level signal crossing into clock_in's domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic rst_in,
  input  logic data_in,
  output logic data_out
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // old value, which is what makes this a shift chain rather than a wire.
  always_ff @(posedge clock_in or posedge rst_in) begin
    if (rst_in) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], data_in};
    end
  end

  assign data_out = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock in the generated clock domain and sequences the user
// reset: release after sustained lock, reassert and hold on any lock loss.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                    clock_in,
  input  logic                    rst_in,
  input  logic                    pll_lock_in,
  output logic                    rst_out,
  output logic                    ready_out,
  output logic [1:0]              state_out,
  output logic [LOSS_COUNT_W-1:0] loss_count
);

  localparam int               CNT_W       = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             loss_inc;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock_in (clock_in),
    .rst_in   (rst_in),
    .data_in  (pll_lock_in),
    .data_out (lock_s)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    loss_inc  = 1'b0;
    unique case (state)
      WAIT_LOCK: if (lock_s) state_nxt = STABLE;
      STABLE: begin
        if (!lock_s)                 state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = HOLD;
          loss_inc  = 1'b1;
        end
      end
      HOLD: if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase
    // Any state change (glitch, release, loss, hold expiry) restarts the count.
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs follow the next state so rst_out/ready_out change on the same
  // edge as the transition; rst_in forces rst_out high without a clock.
  always_ff @(posedge clock_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      rst_out    <= 1'b1;
      ready_out  <= 1'b0;
      loss_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_out   <= (state_nxt != RUN);
      ready_out <= (state_nxt == RUN);
      if (loss_inc && (loss_count != '1)) loss_count <= loss_count + 1'b1;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (SYNC_STAGES=2, STABLE_CYCLES=8,
// HOLD_CYCLES=4) against a lock-history reference model.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;

  logic       clock_in = 1'b0;
  logic       rst_in;
  logic       pll_lock_in;
  logic       rst_out;
  logic       ready_out;
  logic [1:0] state_out;
  logic [7:0] loss_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_en = 1'b0;

  // Reference model: lock history, consecutive-lock qualification count,
  // remaining hold cycles, run flag and loss tally.
  bit q_hist[$];
  int qual      = 0;
  int hold_left = 0;
  bit running   = 1'b0;
  int losses    = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clock_in    (clock_in),
    .rst_in      (rst_in),
    .pll_lock_in (pll_lock_in),
    .rst_out     (rst_out),
    .ready_out   (ready_out),
    .state_out   (state_out),
    .loss_count  (loss_count)
  );

  initial begin
    #50;
    forever #5 clock_in = ~clock_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q_hist.delete();
    qual      = 0;
    hold_left = 0;
    running   = 1'b0;
    losses    = 0;
  endtask

  // The FSM sees the lock value sampled SYNC edges earlier (0 until the
  // history has filled after reset).
  task automatic model_step(input bit lock_sample);
    bit ls;
    ls = (q_hist.size() >= SYNC) ? q_hist[SYNC-1] : 1'b0;
    q_hist.push_front(lock_sample);
    if (q_hist.size() > SYNC) void'(q_hist.pop_back());
    if (hold_left > 0) begin
      hold_left--;
    end else if (running) begin
      if (!ls) begin
        running   = 1'b0;
        hold_left = HOLD;
        if (losses < 255) losses++;
      end
    end else if (ls) begin
      qual++;
      if (qual == STABLE + 1) begin
        running = 1'b1;
        qual    = 0;
      end
    end else begin
      qual = 0;
    end
  endtask

  function automatic logic [1:0] model_state();
    if (hold_left > 0) return 2'd3;
    if (running)       return 2'd2;
    if (qual > 0)      return 2'd1;
    return 2'd0;
  endfunction

  // Compare process: steps the model on every clock edge or reset assertion
  // and checks all outputs shortly after.
  initial begin
    forever begin
      @(posedge clock_in or posedge rst_in);
      if (rst_in) model_reset();
      else        model_step(pll_lock_in);
      #1;
      if (model_en) begin
        check("model rst_out",    rst_out,    !running);
        check("model ready_out",  ready_out,  running);
        check("model state_out",  state_out,  model_state());
        check("model loss_count", loss_count, losses);
      end
    end
  end

  task automatic wait_ready(input logic lvl, input int budget);
    int k = 0;
    while (ready_out !== lvl && k < budget) begin
      @(posedge clock_in);
      #1;
      k++;
    end
    if (ready_out !== lvl) check("ready wait timeout", ready_out, lvl);
  endtask

  initial begin
    rst_in      = 1'b1;
    pll_lock_in = 1'b0;
    #20;
    check("noclk rst_out",    rst_out,    1);
    check("noclk ready_out",  ready_out,  0);
    check("noclk loss_count", loss_count, 0);
    check("noclk state_out",  state_out,  0);
    model_en    = 1'b1;
    pll_lock_in = 1'b1;
    repeat (3) @(negedge clock_in);
    rst_in = 1'b0;

    // Release latency with lock already high: E0 is the first edge after release.
    for (int i = 0; i <= 10; i++) begin
      @(posedge clock_in);
      #1;
      if (i == 1) check("E1 state", state_out, 0);
      if (i == 2) check("E2 state", state_out, 1);
      if (i == 9) check("E9 rst_out", rst_out, 1);
      if (i == 10) begin
        check("E10 rst_out",   rst_out,   0);
        check("E10 ready_out", ready_out, 1);
        check("E10 state",     state_out, 2);
      end
    end

    // Lock loss in RUN; lock returns before F3 but HOLD ignores it.
    @(negedge clock_in);
    pll_lock_in = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      @(posedge clock_in);
      #1;
      if (i == 1) check("F1 rst_out", rst_out, 0);
      if (i == 2) begin
        check("F2 rst_out",    rst_out,    1);
        check("F2 ready_out",  ready_out,  0);
        check("F2 loss_count", loss_count, 1);
        check("F2 state",      state_out,  3);
        @(negedge clock_in);
        pll_lock_in = 1'b1;
      end
      if (i == 5) check("F5 state", state_out, 3);
      if (i == 6) check("F6 state", state_out, 0);
      if (i == 7) check("F7 state", state_out, 1);
    end
    wait_ready(1'b1, 40);

    // Asynchronous reset mid-cycle in RUN.
    @(posedge clock_in);
    #3;
    rst_in = 1'b1;
    #1;
    check("async rst_out",    rst_out,    1);
    check("async ready_out",  ready_out,  0);
    check("async loss_count", loss_count, 0);
    check("async state",      state_out,  0);
    pll_lock_in = 1'b0;
    @(negedge clock_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clock_in);
    pll_lock_in = 1'b1;

    // Glitch at cnt=5 in STABLE restarts qualification from zero.
    for (int i = 0; i <= 20; i++) begin
      @(posedge clock_in);
      #1;
      if (i == 7)  check("glitch E7 state",  state_out, 1);
      if (i == 9)  check("glitch E9 state",  state_out, 0);
      if (i == 12) check("glitch G2 state",  state_out, 1);
      if (i == 19) check("glitch G9 rst_out", rst_out, 1);
      if (i == 20) begin
        check("glitch G10 rst_out", rst_out,   0);
        check("glitch G10 state",   state_out, 2);
      end
      @(negedge clock_in);
      pll_lock_in = (i >= 6 && i <= 8) ? 1'b0 : 1'b1;
    end

    // 300 losses with random drop lengths; the counter must stop at 255.
    for (int n = 0; n < 300; n++) begin
      wait_ready(1'b1, 60);
      @(negedge clock_in);
      pll_lock_in = 1'b0;
      wait_ready(1'b0, 10);
      repeat ($urandom_range(0, 5)) @(negedge clock_in);
      pll_lock_in = 1'b1;
    end
    wait_ready(1'b1, 60);
    check("loss saturation", loss_count, 255);

    // Random lock activity with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock_in);
      if ($urandom_range(0, 19) == 0) pll_lock_in = ~pll_lock_in;
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst_in = 1'b1;
        @(negedge clock_in);
        rst_in = 1'b0;
      end
    end

    repeat (2) @(posedge clock_in);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
